pwm_multi_channel: RTL and testbench

// - NCH-channel PWM generator sharing one programmable timebase.
// - Supports edge-aligned and center-aligned modes, per-channel output polarity, and a runtime period.
// - Duty writes go to shadow registers and apply only at period boundaries, so outputs never glitch.
// - Sits between the board/register interface (switches, CSR) and the LED/motor pins.

---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_timebase.sv | 64 ++++++
 rtl/pwm_multi_channel.sv | 81 ++++++++
 tb/tb_pwm_multi_channel.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM block.
package pwm_pkg;

  localparam int unsigned CBITS_DEFAULT = 17;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  // Unsigned compare; callers zero-extend their CBITS-wide operands to 32 bits.
  function automatic logic pwm_cmp(input logic [31:0] cnt, input logic [31:0] duty);
    return cnt < duty;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: edge or up/down counter with period and mode captured at boundaries.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned CBITS = CBITS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             center_mode,
  input  logic [CBITS-1:0] period,
  output logic [CBITS-1:0] cnt,
  output logic             boundary,
  output logic             load
);

  logic [CBITS-1:0] cnt_q, cnt_d;
  logic [CBITS-1:0] period_act_q;
  logic             dir_down_q, dir_down_d;
  pwm_mode_e        mode_q;

  always_comb begin
    cnt_d      = cnt_q;
    dir_down_d = dir_down_q;
    if (mode_q == PWM_EDGE) begin
      cnt_d = (cnt_q >= period_act_q) ? '0 : cnt_q + CBITS'(1);
    end else if (!dir_down_q) begin
      if (cnt_q >= period_act_q) begin
        dir_down_d = 1'b1;
        cnt_d      = (period_act_q == '0) ? '0 : cnt_q - CBITS'(1);
      end else begin
        cnt_d = cnt_q + CBITS'(1);
      end
    end else begin
      cnt_d = cnt_q - CBITS'(1);
    end
    // A boundary is any cycle whose successor count is 0; a new period always starts counting up.
    boundary = en && (cnt_d == '0);
    load     = boundary || !en;
    if (load) begin
      cnt_d      = '0;
      dir_down_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      dir_down_q   <= 1'b0;
      period_act_q <= '1;
      mode_q       <= PWM_EDGE;
    end else begin
      cnt_q      <= cnt_d;
      dir_down_q <= dir_down_d;
      if (load) begin
        period_act_q <= period;
        mode_q       <= pwm_mode_e'(center_mode);
      end
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pwm_multi_channel.sv
// NCH-channel PWM generator with shadowed duty registers and a shared timebase.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CBITS = CBITS_DEFAULT,
  localparam int unsigned CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             center_mode,
  input  logic [CBITS-1:0] period,
  input  logic [NCH-1:0]   pol,
  input  logic             wr_en,
  input  logic [CHW-1:0]   wr_ch,
  input  logic [CBITS-1:0] wr_duty,
  output logic [NCH-1:0]   pwm_out,
  output logic             period_start,
  output logic [CBITS-1:0] cnt
);

  logic [CBITS-1:0] cnt_q;
  logic             boundary, load;
  logic [CBITS-1:0] duty_sh_q  [NCH];
  logic [CBITS-1:0] duty_act_q [NCH];
  logic [CBITS-1:0] duty_sh_d  [NCH];
  logic [NCH-1:0]   out_d;
  logic [NCH-1:0]   pwm_out_q;
  logic             period_start_q;

  pwm_timebase #(
    .CBITS(CBITS)
  ) u_timebase (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .center_mode(center_mode),
    .period     (period),
    .cnt        (cnt_q),
    .boundary   (boundary),
    .load       (load)
  );

  // Out-of-range channel indices never match, so those writes are dropped.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      duty_sh_d[i] = (wr_en && (wr_ch == CHW'(i))) ? wr_duty : duty_sh_q[i];
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : gen_cmp
    assign out_d[g] = en ? (pwm_cmp(32'(cnt_q), 32'(duty_act_q[g])) ^ pol[g]) : pol[g];
  end

  // The shadow next-value feeds duty_act so a write in the boundary cycle lands immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        duty_sh_q[i]  <= '0;
        duty_act_q[i] <= '0;
      end
      pwm_out_q      <= '0;
      period_start_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        duty_sh_q[i] <= duty_sh_d[i];
        if (load) begin
          duty_act_q[i] <= duty_sh_d[i];
        end
      end
      pwm_out_q      <= out_d;
      period_start_q <= boundary;
    end
  end

  assign pwm_out      = pwm_out_q;
  assign period_start = period_start_q;
  assign cnt          = cnt_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel: vector table, directed corners, random vs model.
module tb_pwm_multi_channel;

  localparam int NCH = 4;
  localparam int CB  = 17;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, center_mode, wr_en;
  logic [CB-1:0] period, wr_duty;
  logic [NCH-1:0] pol;
  logic [1:0]    wr_ch;
  logic [NCH-1:0] pwm_out;
  logic          period_start;
  logic [CB-1:0] cnt;

  pwm_multi_channel #(
    .NCH  (NCH),
    .CBITS(CB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .center_mode (center_mode),
    .period      (period),
    .pol         (pol),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_duty     (wr_duty),
    .pwm_out     (pwm_out),
    .period_start(period_start),
    .cnt         (cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: position within the current period, mapped to a count by plain arithmetic.
  function automatic int plen(input int pa, input bit c);
    if (c) return (pa == 0) ? 1 : 2 * pa;
    return pa + 1;
  endfunction

  function automatic int cnt_at(input int pos, input int pa, input bit c);
    return (c && pos > pa) ? 2 * pa - pos : pos;
  endfunction

  int            m_pos = 0;
  int            m_pa = 131071;
  bit            m_c = 1'b0;
  logic [CB-1:0] m_sh  [NCH];
  logic [CB-1:0] m_act [NCH];
  logic [CB-1:0] shn   [NCH];
  logic [NCH-1:0] m_out = '0;
  logic [NCH-1:0] m_pol = '0;
  logic          m_ps = 1'b0;
  logic          m_en = 1'b0;

  always_comb begin
    for (int i = 0; i < NCH; i++) shn[i] = m_sh[i];
    if (wr_en && int'(wr_ch) < NCH) shn[wr_ch] = wr_duty;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos <= 0;
      m_pa  <= (1 << CB) - 1;
      m_c   <= 1'b0;
      m_out <= '0;
      m_ps  <= 1'b0;
      m_en  <= 1'b0;
      m_pol <= '0;
      for (int i = 0; i < NCH; i++) begin
        m_sh[i]  <= '0;
        m_act[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        m_out[i] <= en ? ((cnt_at(m_pos, m_pa, m_c) < int'(m_act[i])) ^ pol[i]) : pol[i];
        m_sh[i]  <= shn[i];
      end
      m_en  <= en;
      m_pol <= pol;
      if (!en || m_pos == plen(m_pa, m_c) - 1) begin
        m_pos <= 0;
        m_pa  <= int'(period);
        m_c   <= center_mode;
        m_ps  <= en;
        for (int i = 0; i < NCH; i++) m_act[i] <= shn[i];
      end else begin
        m_pos <= m_pos + 1;
        m_ps  <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model plus the liveness bound.
  int            lv [NCH];
  int            lv_pa = 0;
  logic [CB-1:0] lv_act [NCH];

  always @(negedge clk) begin
    check("cnt", 64'(cnt), 64'(cnt_at(m_pos, m_pa, m_c)));
    check("pwm_out", 64'(pwm_out), 64'(m_out));
    check("period_start", 64'(period_start), 64'(m_ps));
    for (int i = 0; i < NCH; i++) begin
      if (!m_en || lv_pa != m_pa || lv_act[i] != m_act[i] || pwm_out[i] == m_pol[i]) lv[i] = 0;
      else lv[i] = lv[i] + 1;
      if (m_en && int'(m_act[i]) <= m_pa) check("liveness", 64'(lv[i] > 2 * (m_pa + 1)), 64'(0));
      lv_act[i] = m_act[i];
    end
    lv_pa = m_pa;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ps();
    int n = 0;
    tick();
    while (!period_start && n < 400) begin
      tick();
      n++;
    end
    check("period_start_seen", 64'(period_start), 64'(1));
  endtask

  int mlen;
  int hi_cnt [NCH];

  // Starts on a period_start sample; ends on the next one, covering exactly one period.
  task automatic measure(input int wat, input int wch, input int wv);
    mlen = 0;
    for (int i = 0; i < NCH; i++) hi_cnt[i] = 0;
    do begin
      if (int'(cnt) == wat) begin
        wr_en   = 1'b1;
        wr_ch   = wch[1:0];
        wr_duty = wv[CB-1:0];
      end
      tick();
      wr_en = 1'b0;
      mlen++;
      for (int i = 0; i < NCH; i++) hi_cnt[i] += int'(pwm_out[i]);
    end while (!period_start && mlen < 400);
  endtask

  task automatic configure(input int per, input bit ctr, input logic [NCH-1:0] p,
                           input logic [NCH-1:0][CB-1:0] d);
    en          = 1'b0;
    period      = per[CB-1:0];
    center_mode = ctr;
    pol         = p;
    for (int i = 0; i < NCH; i++) begin
      wr_en   = 1'b1;
      wr_ch   = 2'(i);
      wr_duty = d[i];
      tick();
    end
    wr_en = 1'b0;
    tick();
    en = 1'b1;
  endtask

  typedef struct packed {
    logic [CB-1:0]           per;
    logic                    ctr;
    logic [NCH-1:0]          pol;
    logic [NCH-1:0][CB-1:0]  duty;
    logic [8:0]              len;
    logic [NCH-1:0][8:0]     hi;
  } row_t;

  row_t rows [6];

  initial begin
    rows[0] = '{per: 9, ctr: 0, pol: 4'b0000, duty: {17'd12, 17'd10, 17'd3, 17'd0},
                len: 10, hi: {9'd10, 9'd10, 9'd3, 9'd0}};
    rows[1] = '{per: 9, ctr: 0, pol: 4'b0101, duty: {17'd12, 17'd10, 17'd3, 17'd0},
                len: 10, hi: {9'd10, 9'd0, 9'd3, 9'd10}};
    rows[2] = '{per: 8, ctr: 1, pol: 4'b0000, duty: {17'd9, 17'd8, 17'd0, 17'd3},
                len: 16, hi: {9'd16, 9'd15, 9'd0, 9'd5}};
    rows[3] = '{per: 0, ctr: 0, pol: 4'b0000, duty: {17'd1, 17'd0, 17'd1, 17'd0},
                len: 1, hi: {9'd1, 9'd0, 9'd1, 9'd0}};
    rows[4] = '{per: 1, ctr: 1, pol: 4'b0000, duty: {17'd1, 17'd0, 17'd2, 17'd1},
                len: 2, hi: {9'd1, 9'd0, 9'd2, 9'd1}};
    rows[5] = '{per: 4, ctr: 0, pol: 4'b0000, duty: {17'd2, 17'd1, 17'd5, 17'd4},
                len: 5, hi: {9'd2, 9'd1, 9'd5, 9'd4}};

    rst_n = 1'b0; en = 1'b0; center_mode = 1'b0; period = '0; pol = '0;
    wr_en = 1'b0; wr_ch = '0; wr_duty = '0;
    for (int i = 0; i < NCH; i++) lv[i] = 0;
    tick();
    tick();
    check("reset pwm_out", 64'(pwm_out), 64'(0));
    check("reset cnt", 64'(cnt), 64'(0));
    check("reset period_start", 64'(period_start), 64'(0));
    rst_n = 1'b1;
    tick();

    for (int r = 0; r < 6; r++) begin
      configure(int'(rows[r].per), rows[r].ctr, rows[r].pol, rows[r].duty);
      wait_ps();
      measure(-1, 0, 0);
      check($sformatf("row%0d len", r), 64'(mlen), 64'(rows[r].len));
      for (int i = 0; i < NCH; i++)
        check($sformatf("row%0d ch%0d high", r, i), 64'(hi_cnt[i]), 64'(rows[r].hi[i]));
    end

    // Mid-period write waits for the boundary; a write in the boundary cycle goes straight through.
    configure(9, 1'b0, 4'b0000, {17'd0, 17'd0, 17'd3, 17'd0});
    wait_ps();
    measure(4, 1, 7);
    check("shadow current period", 64'(hi_cnt[1]), 64'(3));
    measure(9, 1, 5);
    check("shadow next period", 64'(hi_cnt[1]), 64'(7));
    measure(-1, 0, 0);
    check("write-through period", 64'(hi_cnt[1]), 64'(5));

    // Polarity, then en=0 forces the inactive level within one cycle.
    configure(9, 1'b0, 4'b0101, {17'd2, 17'd2, 17'd2, 17'd2});
    wait_ps();
    measure(-1, 0, 0);
    check("pol ch0 high", 64'(hi_cnt[0]), 64'(8));
    check("pol ch1 high", 64'(hi_cnt[1]), 64'(2));
    en = 1'b0;
    tick();
    check("en0 pwm_out", 64'(pwm_out), 64'(4'b0101));
    check("en0 cnt", 64'(cnt), 64'(0));
    repeat (5) begin
      tick();
      check("en0 period_start", 64'(period_start), 64'(0));
    end

    // Asynchronous reset mid-period, then duty_act stays 0 until a reload.
    configure(9, 1'b0, 4'b0000, {17'd12, 17'd10, 17'd3, 17'd6});
    wait_ps();
    for (int n = 0; n < 40 && int'(cnt) != 5; n++) tick();
    check("reached cnt5", 64'(cnt), 64'(5));
    rst_n = 1'b0;
    #1;
    check("async reset pwm_out", 64'(pwm_out), 64'(0));
    check("async reset cnt", 64'(cnt), 64'(0));
    check("async reset period_start", 64'(period_start), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    repeat (12) begin
      tick();
      check("post-reset idle", 64'(pwm_out), 64'(0));
    end
    wr_en = 1'b1; wr_ch = 2'd0; wr_duty = 17'd4;
    tick();
    wr_en = 1'b0;
    repeat (4) begin
      tick();
      check("post-reset no boundary", 64'(pwm_out), 64'(0));
    end
    en = 1'b0;
    tick();
    en = 1'b1;
    wait_ps();
    measure(-1, 0, 0);
    check("post-reset reload ch0", 64'(hi_cnt[0]), 64'(4));
    check("post-reset reload len", 64'(mlen), 64'(10));

    // Randomized traffic; every cycle is compared with the model.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        wr_en   = 1'b1;
        wr_ch   = 2'($urandom_range(0, NCH - 1));
        wr_duty = 17'($urandom_range(0, 14));
      end else begin
        wr_en = 1'b0;
      end
      if ($urandom_range(0, 49) == 0) period = 17'($urandom_range(0, 12));
      if ($urandom_range(0, 79) == 0) center_mode = ~center_mode;
      if ($urandom_range(0, 99) == 0) pol = 4'($urandom_range(0, 15));
      if (en) en = ($urandom_range(0, 149) != 0);
      else en = ($urandom_range(0, 3) == 0);
      tick();
    end
    wr_en = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
